// File: rtl/permutation_sequencer_pkg.sv
// Shared types and constants for the ASCON permutation round sequencer.
// Optional feature macro: PERM_SEQ_ABORT_EN (adds abort_i to the sequencer bus).
package permutation_sequencer_pkg;

    localparam int NB_ROUNDS_MAX_DEF = 12;
    localparam int ROUND_W_DEF       = 4;

    typedef enum logic [1:0] {SEQ_IDLE, SEQ_RUN, SEQ_DONE} type_seq_state;

    localparam logic [3:0] ROUNDS_PA = 4'd12;
    localparam logic [3:0] ROUNDS_PB = 4'd6;

endpackage

// File: rtl/permutation_sequencer_if.sv
// Handshake and datapath-control bus between the mode FSM (master) and the sequencer (slave).
// Optional feature macro: PERM_SEQ_ABORT_EN adds abort_i.
interface permutation_sequencer_if #(parameter int ROUND_W = 4);

    logic               start_i;
    logic [ROUND_W-1:0] nb_rounds_i;
    logic               ready_o;
    logic               busy_o;
    logic [ROUND_W-1:0] round_o;
    logic               input_select_o;
    logic               done_o;
    logic               err_o;
`ifdef PERM_SEQ_ABORT_EN
    logic               abort_i;

    modport master (
        output start_i, nb_rounds_i, abort_i,
        input  ready_o, busy_o, round_o, input_select_o, done_o, err_o
    );

    modport slave (
        input  start_i, nb_rounds_i, abort_i,
        output ready_o, busy_o, round_o, input_select_o, done_o, err_o
    );
`else
    modport master (
        output start_i, nb_rounds_i,
        input  ready_o, busy_o, round_o, input_select_o, done_o, err_o
    );

    modport slave (
        input  start_i, nb_rounds_i,
        output ready_o, busy_o, round_o, input_select_o, done_o, err_o
    );
`endif

endinterface

// File: rtl/permutation_sequencer_round_counter.sv
// Loadable down-counter with zero flag; tracks the rounds still to run after the current one.
module round_counter #(
    parameter int ROUND_W = 4
) (
    input  logic               clock_i,
    input  logic               resetb_i,
    input  logic               load,
    input  logic [ROUND_W-1:0] load_value,
    input  logic               decrement,
    output logic [ROUND_W-1:0] count,
    output logic               zero
);

    always_ff @(posedge clock_i) begin
        if (resetb_i) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (decrement && (count != '0)) begin
            count <= count - ROUND_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/permutation_sequencer.sv
// ASCON permutation round sequencer: drives round index and input select for p^a, then pulses done.
// Optional feature macro: PERM_SEQ_ABORT_EN (abort_i cancels a running permutation).
module permutation_sequencer
    import permutation_sequencer_pkg::*;
#(
    parameter int NB_ROUNDS_MAX = NB_ROUNDS_MAX_DEF,
    parameter int ROUND_W       = ROUND_W_DEF
) (
    input  logic                   clock_i,
    input  logic                   resetb_i,
    permutation_sequencer_if.slave seq
);

    localparam logic [ROUND_W-1:0] MAX_W = ROUND_W'(NB_ROUNDS_MAX);

    type_seq_state      state;
    type_seq_state      state_next;
    logic               legal;
    logic               accept;
    logic               abort_req;
    logic               last_round;
    logic [ROUND_W-1:0] remaining;
    logic [ROUND_W-1:0] round_q;
    logic               select_q;
    logic               err_q;

    assign legal  = (seq.nb_rounds_i != '0) && (seq.nb_rounds_i <= MAX_W);
    assign accept = (state == SEQ_IDLE) && seq.start_i && legal;

`ifdef PERM_SEQ_ABORT_EN
    assign abort_req = seq.abort_i && (state != SEQ_IDLE);
`else
    assign abort_req = 1'b0;
`endif

    round_counter #(.ROUND_W(ROUND_W)) u_round_counter (
        .clock_i    (clock_i),
        .resetb_i   (resetb_i),
        .load       (accept),
        .load_value (seq.nb_rounds_i - ROUND_W'(1)),
        .decrement  ((state == SEQ_RUN) && !abort_req),
        .count      (remaining),
        .zero       (last_round)
    );

    always_ff @(posedge clock_i) begin
        if (resetb_i) begin
            state <= SEQ_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            SEQ_IDLE: if (accept) state_next = SEQ_RUN;
            SEQ_RUN: begin
                if (abort_req) begin
                    state_next = SEQ_IDLE;
                end else if (last_round) begin
                    state_next = SEQ_DONE;
                end
            end
            SEQ_DONE: state_next = SEQ_IDLE;
            default:  state_next = SEQ_IDLE;
        endcase
    end

    // Round index stops at the last round so it never passes NB_ROUNDS_MAX-1;
    // select drops to 0 only for the first round of a run.
    always_ff @(posedge clock_i) begin
        if (resetb_i) begin
            round_q  <= '0;
            select_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            err_q <= (state == SEQ_IDLE) && seq.start_i && !legal;
            if (accept) begin
                round_q  <= MAX_W - seq.nb_rounds_i;
                select_q <= 1'b0;
            end else if ((state == SEQ_RUN) && !abort_req) begin
                select_q <= 1'b1;
                if (!last_round) begin
                    round_q <= round_q + ROUND_W'(1);
                end
            end
        end
    end

    assign seq.ready_o        = (state == SEQ_IDLE);
    assign seq.busy_o         = (state == SEQ_RUN);
    assign seq.done_o         = (state == SEQ_DONE);
    assign seq.round_o        = round_q;
    assign seq.input_select_o = select_q;
    assign seq.err_o          = err_q;

endmodule

// File: tb/tb_permutation_sequencer.sv
// Self-checking bench for permutation_sequencer: directed cases then random traffic against a cycle-queue model.
// Abort cases are exercised when PERM_SEQ_ABORT_EN is defined.
module tb_permutation_sequencer;
    import permutation_sequencer_pkg::*;

    localparam int MAX = 12;
    localparam int W   = 4;

    typedef struct {
        int round;
        bit sel;
        bit is_done;
    } cycle_t;

    logic clock_i  = 1'b0;
    logic resetb_i = 1'b1;

    permutation_sequencer_if #(.ROUND_W(W)) seq_bus ();

    permutation_sequencer #(.NB_ROUNDS_MAX(MAX), .ROUND_W(W)) dut (
        .clock_i  (clock_i),
        .resetb_i (resetb_i),
        .seq      (seq_bus)
    );

    always #5 clock_i = ~clock_i;

    // Model: queue of expected outputs for each upcoming busy cycle; empty means idle.
    cycle_t expQ[$];
    int     lastRound;
    bit     lastSel;
    bit     expErr;
    int     compared;
    int     mismatched;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", tag, $time, observed, expected);
        end
    endtask

    task automatic modelEdge(input bit start, input int nb, input bit rst, input bit abort);
        cycle_t c;
        if (rst) begin
            expQ.delete();
            lastRound = 0;
            lastSel   = 1'b0;
            expErr    = 1'b0;
        end else begin
            expErr = 1'b0;
            if (expQ.size() == 0) begin
                if (start) begin
                    if (nb >= 1 && nb <= MAX) begin
                        for (int k = 0; k < nb; k++) begin
                            c.round   = MAX - nb + k;
                            c.sel     = (k > 0);
                            c.is_done = 1'b0;
                            expQ.push_back(c);
                        end
                        c.round   = MAX - 1;
                        c.sel     = 1'b1;
                        c.is_done = 1'b1;
                        expQ.push_back(c);
                    end else begin
                        expErr = 1'b1;
                    end
                end
            end else begin
                lastRound = expQ[0].round;
                lastSel   = expQ[0].sel;
                if (abort) expQ.delete();
                else void'(expQ.pop_front());
            end
        end
    endtask

    task automatic applyStimulus(input bit start, input int nb, input bit rst, input bit abort);
        bit idle;
        @(negedge clock_i);
        resetb_i            = rst;
        seq_bus.start_i     = start;
        seq_bus.nb_rounds_i = W'(nb);
`ifdef PERM_SEQ_ABORT_EN
        seq_bus.abort_i     = abort;
`endif
        @(posedge clock_i);
        modelEdge(start, nb, rst, abort);
        #1;
        idle = (expQ.size() == 0);
        checkOutput("ready", seq_bus.ready_o, idle);
        checkOutput("busy", seq_bus.busy_o, !idle && !expQ[0].is_done);
        checkOutput("done", seq_bus.done_o, !idle && expQ[0].is_done);
        checkOutput("round", seq_bus.round_o, idle ? lastRound : expQ[0].round);
        checkOutput("select", seq_bus.input_select_o, idle ? lastSel : expQ[0].sel);
        checkOutput("err", seq_bus.err_o, expErr);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        compared            = 0;
        mismatched          = 0;
        lastRound           = 0;
        lastSel             = 1'b0;
        expErr              = 1'b0;
        seq_bus.start_i     = 1'b0;
        seq_bus.nb_rounds_i = '0;
`ifdef PERM_SEQ_ABORT_EN
        seq_bus.abort_i     = 1'b0;
`endif

        $display("[TB] reset and idle");
        applyStimulus(1'b0, 0, 1'b1, 1'b0);
        applyStimulus(1'b0, 0, 1'b1, 1'b0);
        idleCycles(2);

        $display("[TB] p^12, p^6, p^1");
        applyStimulus(1'b1, int'(ROUNDS_PA), 1'b0, 1'b0);
        idleCycles(14);
        applyStimulus(1'b1, int'(ROUNDS_PB), 1'b0, 1'b0);
        idleCycles(8);
        applyStimulus(1'b1, 1, 1'b0, 1'b0);
        idleCycles(3);

        $display("[TB] illegal round counts");
        applyStimulus(1'b1, 0, 1'b0, 1'b0);
        idleCycles(1);
        applyStimulus(1'b1, 13, 1'b0, 1'b0);
        idleCycles(1);
        applyStimulus(1'b1, 15, 1'b0, 1'b0);
        idleCycles(1);

        $display("[TB] start held during p^6");
        for (int i = 0; i < 9; i++) applyStimulus(1'b1, 6, 1'b0, 1'b0);
        idleCycles(10);

        $display("[TB] reset at k=5 of p^12");
        applyStimulus(1'b1, 12, 1'b0, 1'b0);
        idleCycles(5);
        applyStimulus(1'b0, 0, 1'b1, 1'b0);
        idleCycles(3);

`ifdef PERM_SEQ_ABORT_EN
        $display("[TB] abort at k=3 of p^12");
        applyStimulus(1'b1, 12, 1'b0, 1'b0);
        idleCycles(3);
        applyStimulus(1'b0, 0, 1'b0, 1'b1);
        idleCycles(3);
        applyStimulus(1'b0, 0, 1'b0, 1'b1);
        idleCycles(1);
`endif

        $display("[TB] random traffic");
        for (int i = 0; i < 2000; i++) begin
            bit doStart;
            bit doReset;
            bit doAbort;
            doStart = ($urandom_range(0, 3) == 0);
            doReset = ($urandom_range(0, 99) == 0);
`ifdef PERM_SEQ_ABORT_EN
            doAbort = ($urandom_range(0, 29) == 0);
`else
            doAbort = 1'b0;
`endif
            applyStimulus(doStart, int'($urandom_range(0, 15)), doReset, doAbort);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
